// File: rtl/eth_streamtohdr.sv
// Receive-side Ethernet header stripper: splits a MAC frame stream into a 14-byte header
// channel and a byte-0-aligned payload channel. Define ETH_STREAMTOHDR_TYPE_FILTER_EN to drop non-IPv4/ARP frames.
module eth_streamtohdr #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned PADBYTES_W = 5,
  parameter int unsigned MTU_W      = 14,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_eth_streamtohdr_data_val,
  input  logic [DATA_W-1:0]     src_eth_streamtohdr_data,
  input  logic                  src_eth_streamtohdr_startframe,
  input  logic                  src_eth_streamtohdr_endframe,
  input  logic [PADBYTES_W-1:0] src_eth_streamtohdr_padbytes,
  input  logic [MTU_W-1:0]      src_eth_streamtohdr_frame_size,
  output logic                  eth_streamtohdr_src_data_rdy,
  output logic                  eth_streamtohdr_dst_eth_hdr_val,
  output logic [111:0]          eth_streamtohdr_dst_eth_hdr,
  output logic [MTU_W-1:0]      eth_streamtohdr_dst_payload_len,
  input  logic                  dst_eth_streamtohdr_eth_hdr_rdy,
  output logic                  eth_streamtohdr_dst_data_val,
  output logic [DATA_W-1:0]     eth_streamtohdr_dst_data,
  output logic                  eth_streamtohdr_dst_data_last,
  output logic [PADBYTES_W-1:0] eth_streamtohdr_dst_data_padbytes,
  input  logic                  dst_eth_streamtohdr_data_rdy,
  output logic [CNT_W-1:0]      eth_streamtohdr_drop_cnt
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned HDR_B   = 14;
  localparam int unsigned HDR_W   = 8 * HDR_B;
  localparam int unsigned CARRY_W = DATA_W - HDR_W;
  localparam logic [PADBYTES_W-1:0] CARRY_PAD = PADBYTES_W'(BYTES - HDR_B);
  localparam logic [PADBYTES_W-1:0] HDR_PAD   = PADBYTES_W'(HDR_B);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN, DROP} state_t;

  state_t                  state;
  logic                    run;
  logic [CARRY_W-1:0]      carry;
  logic [PADBYTES_W-1:0]   drain_pad;
  logic                    out_free;
  logic                    accept;
  logic                    is_runt;
  logic                    type_ok;
  logic                    tail_short;
  logic [HDR_W-1:0]        top_bytes;

  assign out_free   = !eth_streamtohdr_dst_data_val || dst_eth_streamtohdr_data_rdy;
  assign accept     = src_eth_streamtohdr_data_val && eth_streamtohdr_src_data_rdy;
  assign top_bytes  = src_eth_streamtohdr_data[DATA_W-1 -: HDR_W];
  // Endframe beat carrying 14 or fewer valid bytes
  assign tail_short = src_eth_streamtohdr_padbytes >= CARRY_PAD;
  assign is_runt    = src_eth_streamtohdr_endframe && tail_short;

`ifdef ETH_STREAMTOHDR_TYPE_FILTER_EN
  logic [15:0] ethertype;
  assign ethertype = src_eth_streamtohdr_data[DATA_W-97 -: 16];
  assign type_ok   = (ethertype == 16'h0800) || (ethertype == 16'h0806);
`else
  assign type_ok   = 1'b1;
`endif

  // Input ready; held low for the first cycle out of reset
  always_comb begin
    eth_streamtohdr_src_data_rdy = 1'b0;
    if (run) begin
      case (state)
        IDLE:    eth_streamtohdr_src_data_rdy = !eth_streamtohdr_dst_eth_hdr_val;
        PAYLOAD: eth_streamtohdr_src_data_rdy = out_free;
        DRAIN:   eth_streamtohdr_src_data_rdy = 1'b0;
        DROP:    eth_streamtohdr_src_data_rdy = 1'b1;
        default: eth_streamtohdr_src_data_rdy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                           <= IDLE;
      run                             <= 1'b0;
      eth_streamtohdr_dst_eth_hdr_val <= 1'b0;
      eth_streamtohdr_dst_data_val    <= 1'b0;
      eth_streamtohdr_drop_cnt        <= '0;
    end else begin
      run <= 1'b1;
      if (eth_streamtohdr_dst_eth_hdr_val && dst_eth_streamtohdr_eth_hdr_rdy)
        eth_streamtohdr_dst_eth_hdr_val <= 1'b0;
      if (eth_streamtohdr_dst_data_val && dst_eth_streamtohdr_data_rdy)
        eth_streamtohdr_dst_data_val <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && src_eth_streamtohdr_startframe) begin
            if (is_runt || !type_ok) begin
              eth_streamtohdr_drop_cnt <= eth_streamtohdr_drop_cnt + CNT_W'(1);
              if (!src_eth_streamtohdr_endframe)
                state <= DROP;
            end else begin
              eth_streamtohdr_dst_eth_hdr     <= top_bytes;
              eth_streamtohdr_dst_payload_len <= src_eth_streamtohdr_frame_size - MTU_W'(HDR_B);
              eth_streamtohdr_dst_eth_hdr_val <= 1'b1;
              carry     <= src_eth_streamtohdr_data[CARRY_W-1:0];
              drain_pad <= src_eth_streamtohdr_padbytes + HDR_PAD;
              state     <= src_eth_streamtohdr_endframe ? DRAIN : PAYLOAD;
            end
          end
        end

        // Each input beat completes the previous carry into a full output beat
        PAYLOAD: begin
          if (accept) begin
            eth_streamtohdr_dst_data_val <= 1'b1;
            eth_streamtohdr_dst_data     <= {carry, top_bytes};
            carry                        <= src_eth_streamtohdr_data[CARRY_W-1:0];
            eth_streamtohdr_dst_data_last     <= 1'b0;
            eth_streamtohdr_dst_data_padbytes <= '0;
            if (src_eth_streamtohdr_endframe) begin
              if (tail_short) begin
                eth_streamtohdr_dst_data_last     <= 1'b1;
                eth_streamtohdr_dst_data_padbytes <= src_eth_streamtohdr_padbytes - CARRY_PAD;
                state <= IDLE;
              end else begin
                drain_pad <= src_eth_streamtohdr_padbytes + HDR_PAD;
                state     <= DRAIN;
              end
            end
          end
        end

        DRAIN: begin
          if (out_free) begin
            eth_streamtohdr_dst_data_val      <= 1'b1;
            eth_streamtohdr_dst_data          <= {carry, {HDR_W{1'b0}}};
            eth_streamtohdr_dst_data_last     <= 1'b1;
            eth_streamtohdr_dst_data_padbytes <= drain_pad;
            state <= IDLE;
          end
        end

        DROP: begin
          if (accept && src_eth_streamtohdr_endframe)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_streamtohdr.sv
// Scoreboard bench for eth_streamtohdr: directed frames, expected header/payload queued at issue.
module tb_eth_streamtohdr;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned PW     = 5;
  localparam int unsigned MTU_W  = 14;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned B      = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_val;
  logic [DATA_W-1:0] s_data;
  logic              s_sf, s_ef;
  logic [PW-1:0]     s_pad;
  logic [MTU_W-1:0]  s_fsize;
  logic              s_rdy;
  logic              h_val;
  logic [111:0]      h_hdr;
  logic [MTU_W-1:0]  h_len;
  logic              h_rdy;
  logic              d_val;
  logic [DATA_W-1:0] d_data;
  logic              d_last;
  logic [PW-1:0]     d_pad;
  logic              d_rdy;
  logic [CNT_W-1:0]  drop_cnt;

  always #5 clk = ~clk;

  eth_streamtohdr dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .src_eth_streamtohdr_data_val      (s_val),
    .src_eth_streamtohdr_data          (s_data),
    .src_eth_streamtohdr_startframe    (s_sf),
    .src_eth_streamtohdr_endframe      (s_ef),
    .src_eth_streamtohdr_padbytes      (s_pad),
    .src_eth_streamtohdr_frame_size    (s_fsize),
    .eth_streamtohdr_src_data_rdy      (s_rdy),
    .eth_streamtohdr_dst_eth_hdr_val   (h_val),
    .eth_streamtohdr_dst_eth_hdr       (h_hdr),
    .eth_streamtohdr_dst_payload_len   (h_len),
    .dst_eth_streamtohdr_eth_hdr_rdy   (h_rdy),
    .eth_streamtohdr_dst_data_val      (d_val),
    .eth_streamtohdr_dst_data          (d_data),
    .eth_streamtohdr_dst_data_last     (d_last),
    .eth_streamtohdr_dst_data_padbytes (d_pad),
    .dst_eth_streamtohdr_data_rdy      (d_rdy),
    .eth_streamtohdr_drop_cnt          (drop_cnt)
  );

  typedef struct {
    logic [111:0]     h;
    logic [MTU_W-1:0] len;
  } hdr_exp_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              last;
    logic [PW-1:0]     pad;
  } beat_exp_t;

  hdr_exp_t  hq[$];
  beat_exp_t dq[$];
  int tests = 0;
  int fails = 0;
  int sf_acc = 0;
  bit hold_hdr = 1'b0;
  bit rand_rdy = 1'b0;
  bit bb_done  = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready generation
  always @(posedge clk) begin
    #1;
    d_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    h_rdy = !hold_hdr;
  end

  // Monitor: pop and compare on every handshake
  always @(negedge clk) begin : monitor
    hdr_exp_t          he;
    beat_exp_t         be;
    logic [DATA_W-1:0] m;
    if (rst_n && s_val && s_rdy && s_sf) sf_acc++;
    if (h_val && h_rdy) begin
      if (hq.size() == 0) begin
        tests++; fails++;
        $display("FAIL hdr_unexpected: got %0h expected none", h_hdr);
      end else begin
        he = hq.pop_front();
        check("hdr", DATA_W'(h_hdr), DATA_W'(he.h));
        check("payload_len", DATA_W'(h_len), DATA_W'(he.len));
      end
    end
    if (d_val && d_rdy) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL data_unexpected: got %0h expected none", d_data);
      end else begin
        be = dq.pop_front();
        m  = '1;
        if (be.last) m = m << (8 * be.pad);
        check("data", d_data & m, be.d & m);
        check("last", DATA_W'(d_last), DATA_W'(be.last));
        if (be.last) check("padbytes", DATA_W'(d_pad), DATA_W'(be.pad));
      end
    end
  end

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic sf, input logic ef,
                            input logic [PW-1:0] pad, input logic [MTU_W-1:0] fsize);
    int n = 0;
    s_val = 1'b1; s_data = d; s_sf = sf; s_ef = ef; s_pad = pad; s_fsize = fsize;
    forever begin
      @(negedge clk);
      if (s_rdy) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        tests++; fails++;
        $display("FAIL src_rdy_timeout: got 0 expected 1");
        break;
      end
    end
  endtask

  task automatic send_frame(input int len, input int seed, input logic [15:0] et, input bit fwd);
    logic [7:0]        fb[0:127];
    logic [DATA_W-1:0] d;
    hdr_exp_t          he;
    beat_exp_t         be;
    int nb, pl, pb;
    for (int i = 0; i < 128; i++) fb[i] = 8'(seed + i * 13 + (i >> 3));
    fb[12] = et[15:8];
    fb[13] = et[7:0];
    nb = (len + B - 1) / B;
    if (fwd) begin
      he.h = '0;
      for (int j = 0; j < 14; j++) he.h[111 - 8*j -: 8] = fb[j];
      he.len = MTU_W'(len - 14);
      hq.push_back(he);
      pl = len - 14;
      pb = (pl + B - 1) / B;
      for (int k = 0; k < pb; k++) begin
        be.d = '0;
        for (int j = 0; j < B; j++)
          if (k * B + j < pl) be.d[DATA_W - 1 - 8*j -: 8] = fb[14 + k * B + j];
        be.last = (k == pb - 1);
        be.pad  = be.last ? PW'(pb * B - pl) : '0;
        dq.push_back(be);
      end
    end
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < B; j++) d[DATA_W - 1 - 8*j -: 8] = fb[b * B + j];
      drive_beat(d, b == 0, b == nb - 1, (b == nb - 1) ? PW'(nb * B - len) : PW'(0), MTU_W'(len));
    end
    s_val = 1'b0; s_sf = 1'b0; s_ef = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((hq.size() != 0 || dq.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", hq.size(), dq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_val = 1'b0; s_data = '0; s_sf = 1'b0; s_ef = 1'b0;
    s_pad = '0; s_fsize = '0; d_rdy = 1'b1; h_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_val", DATA_W'(h_val), '0);
    check("rst_data_val", DATA_W'(d_val), '0);
    check("rst_drop_cnt", DATA_W'(drop_cnt), '0);
    check("rst_src_rdy", DATA_W'(s_rdy), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_frame(64, 1, 16'h0800, 1'b1);
    send_frame(60, 2, 16'h0800, 1'b1);
    send_frame(40, 3, 16'h0806, 1'b1);
    send_frame(20, 4, 16'h0800, 1'b1);
    send_frame(10, 5, 16'h0800, 1'b0);
    wait_drain();
    check("drop_cnt_runt10", DATA_W'(drop_cnt), DATA_W'(1));
    send_frame(14, 6, 16'h0800, 1'b0);
    wait_drain();
    check("drop_cnt_runt14", DATA_W'(drop_cnt), DATA_W'(2));

    // Boundary tails under random backpressure
    rand_rdy = 1'b1;
    send_frame(46, 7, 16'h0800, 1'b1);
    send_frame(47, 8, 16'h0800, 1'b1);
    send_frame(15, 9, 16'h0800, 1'b1);
    send_frame(33, 10, 16'h0800, 1'b1);
    send_frame(96, 11, 16'h0800, 1'b1);
    wait_drain();

    // Back-to-back with header held
    hold_hdr = 1'b1;
    @(posedge clk); #1;
    begin
      int base;
      base = sf_acc;
      fork
        begin
          send_frame(64, 12, 16'h0800, 1'b1);
          send_frame(96, 13, 16'h0806, 1'b1);
          bb_done = 1'b1;
        end
      join_none
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("stall_sf_count", DATA_W'(sf_acc - base), DATA_W'(1));
      check("stall_src_rdy", DATA_W'(s_rdy), '0);
      hold_hdr = 1'b0;
      for (int n = 0; n < 3000 && !bb_done; n++) @(posedge clk);
      check("b2b_done", DATA_W'(bb_done), DATA_W'(1));
      wait_drain();
    end
    rand_rdy = 1'b0;

    // Reset mid-frame
    hold_hdr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive_beat({8{32'hA5A5_0800}}, 1'b1, 1'b0, '0, MTU_W'(64));
    s_val = 1'b0; s_sf = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_hdr_val", DATA_W'(h_val), '0);
    check("midrst_data_val", DATA_W'(d_val), '0);
    check("midrst_drop_cnt", DATA_W'(drop_cnt), '0);
    check("midrst_src_rdy", DATA_W'(s_rdy), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_hdr = 1'b0;
    send_frame(64, 14, 16'h0800, 1'b1);
    wait_drain();

`ifdef ETH_STREAMTOHDR_TYPE_FILTER_EN
    send_frame(64, 15, 16'h86DD, 1'b0);
    send_frame(60, 16, 16'h0806, 1'b1);
    wait_drain();
    check("filter_drop_cnt", DATA_W'(drop_cnt), DATA_W'(1));
`endif

    check("hq_empty", DATA_W'(hq.size()), '0);
    check("dq_empty", DATA_W'(dq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
